traffic_sensor: RTL
===================

// Module: traffic_sensor
// PURPOSE
//  Synthesizable car-sensor front end feeding the traffic light controller (trafficFSM).
//  - Counts cars queued on street A and street B.
//  - Drives the traffic-present inputs ta/tb from those counts.
//  - Consumes the controller's light outputs la/lb to drain the queues while a light is green.
//  - Flags illegal light combinations (safety monitor) for the top level and benches.
// PARAMETERS
//  CNT_W          4   width of each queue counter; max queue = 2**CNT_W-1
//  DEPART_CYCLES  2   green cycles per departing car (>=1)
// PORTS
//  clk        in   1      system clock, all state updates on posedge
//  reset      in   1      asynchronous, active-low reset (0 = reset)
//  car_a      in   1      1 = one car arrives on street A this cycle
//  car_b      in   1      1 = one car arrives on street B this cycle
//  la         in   2      light A from controller: 00 green, 01 yellow, 10 red, 11 illegal
//  lb         in   2      light B, same encoding
//  ta         out  1      traffic present on A (cnt_a != 0)
//  tb         out  1      traffic present on B (cnt_b != 0)
//  cnt_a      out  CNT_W  cars queued on A
//  cnt_b      out  CNT_W  cars queued on B
//  ovf_a      out  1      sticky: arrival on A dropped at saturation
//  ovf_b      out  1      sticky: arrival on B dropped at saturation
//  conflict   out  1      sticky: la and lb both non-red in the same cycle
//  bad_code   out  1      sticky: la or lb == 2'b11 seen
// BEHAVIOUR
//  Reset:
//  - reset low clears all registers immediately, independent of clk.
//  - Cleared: counters, departure timers, all outputs (=0), street FSMs (=IDLE).
//  - Reset mid-operation discards queued cars; no departure is credited.
//  Departure timer (one per street):
//  - Counts 0..DEPART_CYCLES-1 while own light == green (00) and count != 0.
//  - Forced to 0 in any cycle where the light is not green or the count is 0.
//  - dep pulse = light green AND count != 0 AND timer == DEPART_CYCLES-1; timer then wraps to 0.
//  - Yellow does not drain the queue.
//  Counter update at each posedge:
//  - Next count = count + arr - dep.
//  - arr and dep together: count unchanged.
//  - arr at max (2**CNT_W-1) with no dep: count holds, ovf_x set.
//  - dep is never generated at count 0, so no underflow.
//  Street FSM, per street, registered:
//  - States: IDLE, WAIT, DRAIN.
//  - IDLE -> WAIT when next count != 0 and light not green.
//  - IDLE -> DRAIN when next count != 0 and light green.
//  - WAIT <-> DRAIN follows the light being green.
//  - Any state -> IDLE when next count == 0.
//  - ta/tb are registered: ta = (state != IDLE).
//  Latency:
//  - car_a high at edge N makes ta=1 and cnt_a=1 after edge N.
//  - The last dep makes ta=0 on the same edge that cnt_a reaches 0.
//  Monitor:
//  - conflict and bad_code are registered, 1-cycle latency, sticky until reset.
//  - They do not affect counting; an illegal code (11) counts as not green.
// TESTING (CNT_W=4, DEPART_CYCLES=2)
//  1. 3 car_a pulses, la=10 -> cnt_a 1,2,3 on successive edges; ta=1 from the first edge; holds at 3.
//  2. Then la=00 -> cnt_a 3->2->1->0 every 2nd edge; ta=0 on the edge cnt_a=0; tb stays 0.
//  3. la=00, cnt_a=2, car_a high on the dep edge -> cnt_a stays 2.
//  4. 17 car_b pulses, lb=10 -> cnt_b saturates at 15; ovf_b=1 and stays 1 until reset; ovf_a=0.
//  5. la=00, lb=01 one cycle -> conflict=1 next edge, sticky; later la=11 -> bad_code=1, no drain on A.
//  6. cnt_a=5 with la=00, reset pulsed low mid-cycle -> all outputs 0 without clk edge; counting resumes from 0 after release.

Source files
------------

// File: rtl/traffic_sensor_if.sv
// Signal bundle between the car sensors, the light controller and traffic_sensor.
// The slave side is the sensor block; the master side drives arrivals and lights.
interface traffic_sensor_if #(
  parameter int CNT_W = 4
);
  logic             car_a;
  logic             car_b;
  logic [1:0]       la;
  logic [1:0]       lb;
  logic             ta;
  logic             tb;
  logic [CNT_W-1:0] cnt_a;
  logic [CNT_W-1:0] cnt_b;
  logic             ovf_a;
  logic             ovf_b;
  logic             conflict;
  logic             bad_code;

  modport master (
    output car_a, car_b, la, lb,
    input  ta, tb, cnt_a, cnt_b, ovf_a, ovf_b, conflict, bad_code
  );

  modport slave (
    input  car_a, car_b, la, lb,
    output ta, tb, cnt_a, cnt_b, ovf_a, ovf_b, conflict, bad_code
  );
endinterface

// File: rtl/traffic_sensor.sv
// Car-queue front end for the traffic light controller: per-street queue counters,
// green-light drain timers, traffic-present flags and a sticky light-safety monitor.

// One street: queue counter, departure timer and IDLE/WAIT/DRAIN presence FSM.
module traffic_sensor_street #(
  parameter int CNT_W         = 4,
  parameter int DEPART_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             car_i,
  input  logic [1:0]       light_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             present_o,
  output logic             ovf_o
);
  localparam int TMR_W = (DEPART_CYCLES > 1) ? $clog2(DEPART_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(DEPART_CYCLES - 1);
  localparam logic [1:0] GREEN = 2'b00;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DRAIN
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             ovf_q, ovf_d;

  logic green;
  logic active;
  logic dep;
  logic at_max;

  // Yellow and the illegal 11 code both count as "not green".
  assign green  = (light_i == GREEN);
  assign active = green && (cnt_q != '0);
  assign dep    = active && (timer_q == TMR_LAST);
  assign at_max = (cnt_q == '1);

  // NOTE: every variable driven here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    timer_d = '0;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;

    if (active && !dep) begin
      timer_d = timer_q + 1'b1;
    end

    if (car_i && !dep) begin
      if (at_max) begin
        ovf_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (dep && !car_i) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Presence FSM looks at the next count so ta changes on the same edge as cnt.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (cnt_d != '0) begin
          state_d = green ? S_DRAIN : S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_d == '0) begin
          state_d = S_IDLE;
        end else if (green) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (cnt_d == '0) begin
          state_d = S_IDLE;
        end else if (!green) begin
          state_d = S_WAIT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; the asynchronous reset clears them without a clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      timer_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      timer_q <= timer_d;
      ovf_q   <= ovf_d;
    end
  end

  assign cnt_o     = cnt_q;
  assign present_o = (state_q != S_IDLE);
  assign ovf_o     = ovf_q;
endmodule

module traffic_sensor #(
  parameter int CNT_W         = 4,
  parameter int DEPART_CYCLES = 2
) (
  input  logic               clk,
  input  logic               reset,
  traffic_sensor_if.slave    bus
);
  localparam logic [1:0] RED     = 2'b10;
  localparam logic [1:0] ILLEGAL = 2'b11;

  logic conflict_q, conflict_d;
  logic bad_code_q, bad_code_d;

  traffic_sensor_street #(
    .CNT_W        (CNT_W),
    .DEPART_CYCLES(DEPART_CYCLES)
  ) u_street_a (
    .clk      (clk),
    .reset    (reset),
    .car_i    (bus.car_a),
    .light_i  (bus.la),
    .cnt_o    (bus.cnt_a),
    .present_o(bus.ta),
    .ovf_o    (bus.ovf_a)
  );

  traffic_sensor_street #(
    .CNT_W        (CNT_W),
    .DEPART_CYCLES(DEPART_CYCLES)
  ) u_street_b (
    .clk      (clk),
    .reset    (reset),
    .car_i    (bus.car_b),
    .light_i  (bus.lb),
    .cnt_o    (bus.cnt_b),
    .present_o(bus.tb),
    .ovf_o    (bus.ovf_b)
  );

  // Safety monitor: observation only, both flags latch until reset.
  always_comb begin
    conflict_d = conflict_q | ((bus.la != RED) && (bus.lb != RED));
    bad_code_d = bad_code_q | (bus.la == ILLEGAL) | (bus.lb == ILLEGAL);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      conflict_q <= 1'b0;
      bad_code_q <= 1'b0;
    end else begin
      conflict_q <= conflict_d;
      bad_code_q <= bad_code_d;
    end
  end

  assign bus.conflict = conflict_q;
  assign bus.bad_code = bad_code_q;
endmodule
